fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter_if.sv | 37 +++
 rtl/fifo_wr_arbiter.sv | 131 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// Shared FIFO write-port bus: producer request/data/grant/ack
// plus the FIFO write port and its status flags.
interface fifo_wr_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
);
    logic [NREQ-1:0]       req_i;
    logic [NREQ*WIDTH-1:0] wdata_i;
    logic [NREQ-1:0]       gnt_o;
    logic [NREQ-1:0]       ack_o;
    logic                  fifo_full_i;
    logic                  fifo_wr_error_i;
    logic                  fifo_wr_en_o;
    logic [WIDTH-1:0]      fifo_wdata_o;

    modport master (
        output req_i,
        output wdata_i,
        output fifo_full_i,
        output fifo_wr_error_i,
        input  gnt_o,
        input  ack_o,
        input  fifo_wr_en_o,
        input  fifo_wdata_o
    );

    modport slave (
        input  req_i,
        input  wdata_i,
        input  fifo_full_i,
        input  fifo_wr_error_i,
        output gnt_o,
        output ack_o,
        output fifo_wr_en_o,
        output fifo_wdata_o
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter giving NREQ producers turns on one
// FIFO write port, up to BURST_LEN beats per grant.
module fifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int WIDTH     = 8,
    parameter int BURST_LEN = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    fifo_wr_arbiter_if.slave bus,
    output logic [2:0]       owner_o,
    output logic             busy_o,
    output logic             err_o,
    output logic [15:0]      beat_cnt_o
);
    typedef enum logic {IDLE, BURST} state_t;

    state_t          state_q, state_d;
    logic [2:0]      owner_q, owner_d;
    logic [2:0]      last_q, last_d;
    logic [4:0]      bcnt_q, bcnt_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [15:0]     beat_q, beat_d;
    logic            err_q, err_d;

    logic             own_req;
    logic [WIDTH-1:0] own_data;
    logic [NREQ-1:0]  own_oh;
    logic             win_vld;
    logic [2:0]       win_idx;
    logic             accept;

    always_comb begin : owner_mux
        own_req  = 1'b0;
        own_data = '0;
        own_oh   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (owner_q == 3'(k)) begin
                own_req   = bus.req_i[k];
                own_data  = bus.wdata_i[k*WIDTH +: WIDTH];
                own_oh[k] = 1'b1;
            end
        end
    end

    // Scan starts one past the previous owner and wraps.
    always_comb begin : rr_pick
        win_vld = 1'b0;
        win_idx = '0;
        for (int i = 1; i <= NREQ; i++) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!win_vld && bus.req_i[k] &&
                    k == (int'(last_q) + i) % NREQ) begin
                    win_vld = 1'b1;
                    win_idx = 3'(k);
                end
            end
        end
    end

    assign accept = (state_q == BURST) && own_req &&
                    !bus.fifo_full_i && !rst_i;

    assign bus.fifo_wr_en_o = accept;
    assign bus.fifo_wdata_o = own_data;
    assign bus.ack_o        = accept ? own_oh : '0;
    assign bus.gnt_o        = gnt_q;
    assign owner_o          = owner_q;
    assign busy_o           = (state_q == BURST);
    assign err_o            = err_q;
    assign beat_cnt_o       = beat_q;

    always_comb begin : next_state
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        bcnt_d  = bcnt_q;
        gnt_d   = gnt_q;
        beat_d  = beat_q + {15'd0, accept};
        err_d   = err_q | bus.fifo_wr_error_i;
        unique case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d = BURST;
                    owner_d = win_idx;
                    last_d  = win_idx;
                    bcnt_d  = '0;
                    gnt_d   = '0;
                    for (int k = 0; k < NREQ; k++) begin
                        if (win_idx == 3'(k)) gnt_d[k] = 1'b1;
                    end
                end
            end
            BURST: begin
                if (!own_req) begin
                    state_d = IDLE;
                    owner_d = '0;
                    gnt_d   = '0;
                end else if (accept) begin
                    bcnt_d = bcnt_q + 5'd1;
                    if (bcnt_q + 5'd1 == 5'(BURST_LEN)) begin
                        state_d = IDLE;
                        owner_d = '0;
                        gnt_d   = '0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= 3'(NREQ - 1);
            bcnt_q  <= '0;
            gnt_q   <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            bcnt_q  <= bcnt_d;
            gnt_q   <= gnt_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: producer models, a small
// FIFO fill model and a scoreboard of expected written beats.
module tb_fifo_wr_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int BLEN  = 4;
    localparam int DEPTH = 16;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [2:0]  owner_o;
    logic        busy_o;
    logic        err_o;
    logic [15:0] beat_cnt_o;

    fifo_wr_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    fifo_wr_arbiter #(
        .NREQ(NREQ), .WIDTH(WIDTH), .BURST_LEN(BLEN)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .bus        (bus),
        .owner_o    (owner_o),
        .busy_o     (busy_o),
        .err_o      (err_o),
        .beat_cnt_o (beat_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [1:0] prod;
        logic [7:0] data;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    seq[NREQ];
    int    exp_seq[NREQ];
    int    fifo_cnt;
    bit    fifo_model;

    function automatic logic [7:0] pdata(int k, int s);
        return 8'((k << 4) | (s & 15));
    endfunction

    task automatic check(string tag, logic [31:0] got,
                         logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, got, exp);
        end
    endtask

    task automatic drive_wdata();
        for (int k = 0; k < NREQ; k++)
            bus.wdata_i[k*WIDTH +: WIDTH] = pdata(k, seq[k]);
    endtask

    task automatic push_burst(int k, int n);
        beat_t e;
        for (int i = 0; i < n; i++) begin
            e.prod = 2'(k);
            e.data = pdata(k, exp_seq[k]);
            exp_q.push_back(e);
            exp_seq[k]++;
        end
    endtask

    // One clock: check the write port mid-cycle, then advance
    // producers and the FIFO fill model just after the edge.
    task automatic step();
        beat_t           e;
        logic [NREQ-1:0] ack_s;
        logic            wr_s;
        @(negedge clk_i);
        ack_s = bus.ack_o;
        wr_s  = bus.fifo_wr_en_o;
        if (rst_i || bus.fifo_full_i)
            check("blocked_no_write", {27'd0, wr_s, ack_s}, 0);
        if (wr_s === 1'b1) begin
            check("write_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("wdata", 32'(bus.fifo_wdata_o), 32'(e.data));
                check("ack_onehot", 32'(ack_s), 32'(1) << e.prod);
            end
        end else begin
            check("ack_idle", 32'(ack_s), 0);
        end
        @(posedge clk_i);
        #1;
        for (int k = 0; k < NREQ; k++)
            if (ack_s[k] === 1'b1) seq[k]++;
        if (wr_s === 1'b1) fifo_cnt++;
        if (fifo_model) bus.fifo_full_i = (fifo_cnt >= DEPTH);
        drive_wdata();
    endtask

    task automatic steps(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk_reset(string tag);
        check({tag, "_gnt"}, 32'(bus.gnt_o), 0);
        check({tag, "_owner"}, 32'(owner_o), 0);
        check({tag, "_busy"}, 32'(busy_o), 0);
        check({tag, "_beat"}, 32'(beat_cnt_o), 0);
        check({tag, "_err"}, 32'(err_o), 0);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int k = 0; k < NREQ; k++) begin
            seq[k]     = 0;
            exp_seq[k] = 0;
        end
        fifo_cnt            = 0;
        fifo_model          = 1'b0;
        bus.req_i           = '0;
        bus.fifo_full_i     = 1'b0;
        bus.fifo_wr_error_i = 1'b0;
        drive_wdata();
        rst_i = 1'b1;
        bus.req_i = 4'b1111;
        steps(2);
        chk_reset("reset");
        bus.req_i = '0;
        rst_i = 1'b0;

        // single producer into a 16-deep FIFO
        fifo_model = 1'b1;
        fifo_cnt   = 0;
        push_burst(0, 16);
        bus.req_i = 4'b0001;
        step();
        check("t1_gnt", 32'(bus.gnt_o), 32'h1);
        check("t1_busy", 32'(busy_o), 1);
        steps(4);
        check("t1_gap_gnt", 32'(bus.gnt_o), 0);
        check("t1_gap_busy", 32'(busy_o), 0);
        step();
        check("t1_regnt", 32'(bus.gnt_o), 32'h1);
        steps(19);
        check("t1_drained", 32'(exp_q.size()), 0);
        check("t1_beats", 32'(beat_cnt_o), 16);
        check("t1_stall_busy", 32'(busy_o), 1);
        check("t1_stall_owner", 32'(owner_o), 0);
        check("t1_err", 32'(err_o), 0);
        bus.req_i = '0;
        fifo_model = 1'b0;
        bus.fifo_full_i = 1'b0;
        steps(2);
        check("t1_release", 32'(busy_o), 0);

        // all four requesting: 0,1,2,3,0
        do_reset();
        for (int b = 0; b < 5; b++) push_burst(b % NREQ, BLEN);
        bus.req_i = 4'b1111;
        for (int b = 0; b < 5; b++) begin
            step();
            check("t2_owner", 32'(owner_o), 32'(b % NREQ));
            check("t2_gnt", 32'(bus.gnt_o),
                  32'(1) << (b % NREQ));
            steps(4);
        end
        bus.req_i = '0;
        steps(2);
        check("t2_drained", 32'(exp_q.size()), 0);
        check("t2_beats", 32'(beat_cnt_o), 20);
        check("t2_idle", 32'(busy_o), 0);

        // early release by producer 2
        do_reset();
        push_burst(2, 2);
        bus.req_i = 4'b0100;
        step();
        check("t3_owner", 32'(owner_o), 2);
        bus.req_i = 4'b1101;
        steps(2);
        bus.req_i = 4'b1001;
        step();
        check("t3_idle_busy", 32'(busy_o), 0);
        check("t3_idle_gnt", 32'(bus.gnt_o), 0);
        step();
        check("t3_next_gnt", 32'(bus.gnt_o), 32'h8);
        check("t3_next_owner", 32'(owner_o), 3);
        bus.req_i = '0;
        steps(2);
        check("t3_drained", 32'(exp_q.size()), 0);
        check("t3_beats", 32'(beat_cnt_o), 2);

        // full stall mid-burst for producer 1
        do_reset();
        push_burst(1, BLEN);
        bus.req_i = 4'b0010;
        step();
        check("t4_owner", 32'(owner_o), 1);
        steps(2);
        bus.fifo_full_i = 1'b1;
        steps(5);
        check("t4_hold_owner", 32'(owner_o), 1);
        check("t4_hold_busy", 32'(busy_o), 1);
        check("t4_hold_gnt", 32'(bus.gnt_o), 32'h2);
        check("t4_hold_beats", 32'(beat_cnt_o), 2);
        bus.fifo_full_i = 1'b0;
        steps(2);
        check("t4_done_busy", 32'(busy_o), 0);
        check("t4_beats", 32'(beat_cnt_o), 4);
        check("t4_drained", 32'(exp_q.size()), 0);

        // reset mid-burst
        push_burst(2, 2);
        bus.req_i = 4'b1111;
        step();
        check("t5_owner", 32'(owner_o), 2);
        steps(2);
        rst_i = 1'b1;
        step();
        chk_reset("t5_reset");
        rst_i = 1'b0;
        step();
        check("t5_gnt", 32'(bus.gnt_o), 32'h1);
        check("t5_owner0", 32'(owner_o), 0);
        bus.req_i = '0;
        steps(2);
        check("t5_drained", 32'(exp_q.size()), 0);

        // sticky write error
        bus.fifo_wr_error_i = 1'b1;
        step();
        bus.fifo_wr_error_i = 1'b0;
        check("t6_err_set", 32'(err_o), 1);
        steps(3);
        check("t6_err_sticky", 32'(err_o), 1);
        do_reset();
        check("t6_err_clr", 32'(err_o), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
